hamming_secded_pipe: RTL and testbench
======================================

# hamming_secded_pipe

Parametrised, pipelined Hamming SECDED (single-error-correct, double-error-detect) encoder/decoder with valid/ready flow control. Per-transaction mode selects encode (data → codeword) or decode (codeword → corrected data and status). Saturating error counters feed the board status logic. This block supersedes the fixed 7-bit combinational Hamming path and sits between the switch/UART input stage and the LED / seven-segment display stage.

## Interface
- DATA_W, 4: data width, legal 4..57.
- CNT_W, 8: width of each error counter.
- Derived, not overridable:
  - PAR_W = smallest P with 2^P ≥ DATA_W+P+1.
  - CW_W = DATA_W+PAR_W+1.
- clk  in  1  Single clock. Reset is synchronous and active-high; all state is sampled on the rising edge.
- rst  in  1  Synchronous, active-high reset.
- in_valid  in  1  Input transaction present.
- in_ready  out  1  Block accepts the input this cycle.
- in_mode  in  1  0 = encode, 1 = decode.
- in_data  in  DATA_W  Data to encode. Ignored in decode mode.
- in_code  in  CW_W  Codeword to decode. Ignored in encode mode.
- out_valid  out  1  Result present.
- out_ready  in  1  Downstream accepts the result.
- out_mode  out  1  Mode of the presented result.
- out_data  out  DATA_W  Decode: corrected data. Encode: copy of the input data.
- out_code  out  CW_W  Encode: the generated codeword. Decode: the corrected codeword.
- out_syndrome  out  PAR_W  Hamming syndrome. Always 0 in encode mode.
- out_single  out  1  Decode only: single error detected and corrected.
- out_double  out  1  Decode only: uncorrectable double error.
- clr_counts  in  1  Synchronous clear of both counters.
- corr_count  out  CNT_W  Saturating count of out_single transfers.
- uncorr_count  out  CNT_W  Saturating count of out_double transfers.

## Operation
- Codeword layout:
  - Bit 0 is the overall even parity over bits 1..CW_W-1.
  - Bit positions 1..CW_W-1 follow standard Hamming numbering. Power-of-two positions hold parity bits. Remaining positions hold data bits in ascending order, data LSB first.
  - Parity bit at position 2^k = XOR of all data positions whose index has bit k set.
- Encode: builds the codeword as above. out_single = out_double = 0.
- Decode:
  - syndrome = XOR of the indices of all set bits in positions 1..CW_W-1.
  - pmis = XOR over all CW_W bits.
- Decode classification:
  - syndrome=0, pmis=0: clean result, no flags.
  - pmis=1: single error. Flip the bit at position syndrome; syndrome=0 means bit 0 itself is flipped. Set out_single.
  - syndrome≠0, pmis=0: double error. Set out_double. Data is extracted uncorrected.
  - syndrome ≥ CW_W with pmis=1: treated as a double error.
- Counters:
  - Increment only on an output transfer (out_valid && out_ready) carrying the corresponding flag.
  - Saturate at 2^CNT_W−1.
  - clr_counts wins over a coincident increment; that event is not counted.

## Timing
- Two register stages:
  - S1 registers the input plus syndrome/parity.
  - S2 registers the corrected result and drives all outputs.
- Latency: 2 cycles from input acceptance to out_valid, with no backpressure.
- Throughput: 1 transaction per cycle.
- Elastic pipeline:
  - A stage loads when it is empty or its content moves on the same cycle.
  - in_ready = !S1_valid || S1 advancing.
  - in_ready is combinational from out_ready. No combinational in_valid→out_valid path.
- While out_valid && !out_ready, all out_* hold stable. No transaction is dropped or duplicated.
- Reset (any cycle, including mid-stream):
  - Next edge: both stage valids cleared, all out_* data/flags 0, counters 0, in_ready 1 from the following cycle.
  - In-flight transactions are discarded.
- Counters are registered. They reflect a transfer one cycle after it.

## Structure
- Package hamming_pkg holds:
  - Function par_w(data_w).
  - Function is_pow2(pos).
  - Position↔data-index map functions.
  - Mode constants MODE_ENC=1'b0, MODE_DEC=1'b1.
- One combinational sub-module, hamming_syndrome #(DATA_W). Input: CW_W-bit vector. Outputs: syndrome, pmis.
  - Encode feeds it the data-filled codeword with zeroed parity bits; the syndrome bits become the parity bits.
  - Decode feeds it the received codeword.
- Counters and the handshake live in the top module.

## Test plan
- DATA_W=4, encode in_data=4'b1010 → 2 cycles later out_code=8'hA5, syndrome 0, no flags.
- Decode 8'hA5 → out_data=4'hA, syndrome 0, no flags. Decode 8'h85 (position 5 flipped) → out_data=4'hA, out_code=8'hA5, syndrome 5, out_single=1, corr_count=1.
- Decode 8'hA4 (bit 0 flipped) → out_data=4'hA, syndrome 0, out_single=1. Decode 8'hC5 (positions 5, 6 flipped) → syndrome 3, out_double=1, out_data=4'hC, uncorr_count=1.
- Backpressure: 6 back-to-back inputs, out_ready low for cycles 3–6 → in_ready drops once both stages are full. All 6 results emerge in order, and outputs stay stable while stalled.
- CNT_W=2: 5 single-error transfers → corr_count saturates at 3. Assert clr_counts in the same cycle as a single-error transfer → count 0.
- DATA_W=11 (CW_W=16) random encode→inject 0/1/2 errors→decode against a model, with rst asserted mid-stream → outputs invalid next cycle and counters 0.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared sizing, codeword position map and mode constants for the Hamming SECDED pipeline.
package hamming_pkg;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    function automatic int par_w(input int data_w);
        int p;
        p = 1;
        while ((1 << p) < data_w + p + 1) p++;
        return p;
    endfunction

    function automatic logic is_pow2(input int pos);
        return (pos > 0) && ((pos & (pos - 1)) == 0);
    endfunction

    // Codeword position holding data bit idx (positions skip 0 and powers of two).
    function automatic int data_pos(input int idx);
        int n;
        n = 0;
        for (int pos = 1; pos < 128; pos++) begin
            if (!is_pow2(pos)) begin
                if (n == idx) return pos;
                n++;
            end
        end
        return 0;
    endfunction

    function automatic int pos_to_idx(input int pos);
        int n;
        n = 0;
        for (int p = 1; p < 128; p++) begin
            if (p >= pos) break;
            if (!is_pow2(p)) n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational Hamming syndrome and overall parity of a full SECDED codeword.
module hamming_syndrome
    import hamming_pkg::*;
#(
    parameter  int DATA_W = 4,
    localparam int PAR_W  = par_w(DATA_W),
    localparam int CW_W   = DATA_W + PAR_W + 1
) (
    input  logic [CW_W-1:0]  code_i,
    output logic [PAR_W-1:0] syndrome_o,
    output logic             pmis_o
);

    always_comb begin
        syndrome_o = '0;
        for (int pos = 1; pos < CW_W; pos++) begin
            if (code_i[pos]) syndrome_o = syndrome_o ^ PAR_W'(pos);
        end
        pmis_o = ^code_i;
    end

endmodule

// File: rtl/hamming_secded_pipe.sv
// Two-stage elastic SECDED encode/decode pipeline with saturating error counters.
module hamming_secded_pipe
    import hamming_pkg::*;
#(
    parameter  int DATA_W = 4,
    parameter  int CNT_W  = 8,
    localparam int PAR_W  = par_w(DATA_W),
    localparam int CW_W   = DATA_W + PAR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CW_W-1:0]   in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_mode,
    output logic [DATA_W-1:0] out_data,
    output logic [CW_W-1:0]   out_code,
    output logic [PAR_W-1:0]  out_syndrome,
    output logic              out_single,
    output logic              out_double,
    input  logic              clr_counts,
    output logic [CNT_W-1:0]  corr_count,
    output logic [CNT_W-1:0]  uncorr_count
);

    function automatic logic [CW_W-1:0] fill_data(input logic [DATA_W-1:0] d);
        logic [CW_W-1:0] c;
        c = '0;
        for (int i = 0; i < DATA_W; i++) c[data_pos(i)] = d[i];
        return c;
    endfunction

    function automatic logic [DATA_W-1:0] extract_data(input logic [CW_W-1:0] c);
        logic [DATA_W-1:0] d;
        for (int i = 0; i < DATA_W; i++) d[i] = c[data_pos(i)];
        return d;
    endfunction

    logic              s1_valid_q, s1_valid_d;
    logic              s1_mode_q, s1_mode_d;
    logic [DATA_W-1:0] s1_data_q, s1_data_d;
    logic [CW_W-1:0]   s1_code_q, s1_code_d;
    logic [PAR_W-1:0]  s1_syn_q, s1_syn_d;
    logic              s1_pmis_q, s1_pmis_d;

    logic              s2_valid_q, s2_valid_d;
    logic              s2_mode_q, s2_mode_d;
    logic [DATA_W-1:0] s2_data_q, s2_data_d;
    logic [CW_W-1:0]   s2_code_q, s2_code_d;
    logic [PAR_W-1:0]  s2_syn_q, s2_syn_d;
    logic              s2_single_q, s2_single_d;
    logic              s2_double_q, s2_double_d;

    logic [CNT_W-1:0]  corr_q, corr_d;
    logic [CNT_W-1:0]  uncorr_q, uncorr_d;

    logic              s1_load, s2_load, xfer;
    logic [CW_W-1:0]   syn_in;
    logic [PAR_W-1:0]  syn_c;
    logic              pmis_c;

    logic [CW_W-1:0]   fix_code;
    logic [DATA_W-1:0] fix_data;
    logic [PAR_W-1:0]  fix_syn;
    logic              fix_single, fix_double;

    assign s2_load  = !s2_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = s1_load;
    assign xfer     = s2_valid_q && out_ready;

    // Encode runs the data-only codeword through the same syndrome logic to get parity.
    assign syn_in = (in_mode == MODE_DEC) ? in_code : fill_data(in_data);

    hamming_syndrome #(.DATA_W(DATA_W)) u_syn (
        .code_i     (syn_in),
        .syndrome_o (syn_c),
        .pmis_o     (pmis_c)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_mode_d  = s1_mode_q;
        s1_data_d  = s1_data_q;
        s1_code_d  = s1_code_q;
        s1_syn_d   = s1_syn_q;
        s1_pmis_d  = s1_pmis_q;
        if (s1_load) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_mode_d = in_mode;
                s1_data_d = in_data;
                s1_code_d = syn_in;
                s1_syn_d  = syn_c;
                s1_pmis_d = pmis_c;
            end
        end
    end

    always_comb begin
        fix_code   = s1_code_q;
        fix_syn    = s1_syn_q;
        fix_single = 1'b0;
        fix_double = 1'b0;
        fix_data   = s1_data_q;
        if (s1_mode_q == MODE_ENC) begin
            for (int k = 0; k < PAR_W; k++) fix_code[1 << k] = s1_syn_q[k];
            fix_code[0] = ^fix_code[CW_W-1:1];
            fix_syn     = '0;
        end else begin
            // Odd overall parity with an out-of-range syndrome cannot be a single flip.
            if (s1_pmis_q) begin
                if (int'(s1_syn_q) < CW_W) begin
                    fix_single = 1'b1;
                    for (int pos = 0; pos < CW_W; pos++) begin
                        if (int'(s1_syn_q) == pos) fix_code[pos] = ~fix_code[pos];
                    end
                end else begin
                    fix_double = 1'b1;
                end
            end else if (s1_syn_q != '0) begin
                fix_double = 1'b1;
            end
            fix_data = extract_data(fix_code);
        end
    end

    always_comb begin
        s2_valid_d  = s2_valid_q;
        s2_mode_d   = s2_mode_q;
        s2_data_d   = s2_data_q;
        s2_code_d   = s2_code_q;
        s2_syn_d    = s2_syn_q;
        s2_single_d = s2_single_q;
        s2_double_d = s2_double_q;
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_mode_d   = s1_mode_q;
                s2_data_d   = fix_data;
                s2_code_d   = fix_code;
                s2_syn_d    = fix_syn;
                s2_single_d = fix_single;
                s2_double_d = fix_double;
            end
        end
    end

    always_comb begin
        corr_d   = corr_q;
        uncorr_d = uncorr_q;
        if (clr_counts) begin
            corr_d   = '0;
            uncorr_d = '0;
        end else if (xfer) begin
            if (s2_single_q && (corr_q != '1))   corr_d   = corr_q + 1'b1;
            if (s2_double_q && (uncorr_q != '1)) uncorr_d = uncorr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_mode_q   <= 1'b0;
            s1_data_q   <= '0;
            s1_code_q   <= '0;
            s1_syn_q    <= '0;
            s1_pmis_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_mode_q   <= 1'b0;
            s2_data_q   <= '0;
            s2_code_q   <= '0;
            s2_syn_q    <= '0;
            s2_single_q <= 1'b0;
            s2_double_q <= 1'b0;
            corr_q      <= '0;
            uncorr_q    <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_mode_q   <= s1_mode_d;
            s1_data_q   <= s1_data_d;
            s1_code_q   <= s1_code_d;
            s1_syn_q    <= s1_syn_d;
            s1_pmis_q   <= s1_pmis_d;
            s2_valid_q  <= s2_valid_d;
            s2_mode_q   <= s2_mode_d;
            s2_data_q   <= s2_data_d;
            s2_code_q   <= s2_code_d;
            s2_syn_q    <= s2_syn_d;
            s2_single_q <= s2_single_d;
            s2_double_q <= s2_double_d;
            corr_q      <= corr_d;
            uncorr_q    <= uncorr_d;
        end
    end

    assign out_valid    = s2_valid_q;
    assign out_mode     = s2_mode_q;
    assign out_data     = s2_data_q;
    assign out_code     = s2_code_q;
    assign out_syndrome = s2_syn_q;
    assign out_single   = s2_single_q;
    assign out_double   = s2_double_q;
    assign corr_count   = corr_q;
    assign uncorr_count = uncorr_q;

endmodule

// File: tb/tb_hamming_secded_pipe.sv
// Directed and model-based checks of the SECDED pipeline at DATA_W=4/CNT_W=2 and DATA_W=11/CNT_W=8.
module tb_hamming_secded_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // DUT A: DATA_W=4, CNT_W=2
    logic       a_vld, a_mode, a_ordy, a_clr;
    logic [3:0] a_data;
    logic [7:0] a_code;
    logic       a_in_ready, a_out_valid, a_out_mode, a_out_single, a_out_double;
    logic [3:0] a_out_data;
    logic [7:0] a_out_code;
    logic [2:0] a_out_syn;
    logic [1:0] a_corr, a_uncorr;

    // DUT B: DATA_W=11, CNT_W=8
    logic        b_vld, b_mode, b_ordy, b_clr;
    logic [10:0] b_data;
    logic [15:0] b_code;
    logic        b_in_ready, b_out_valid, b_out_mode, b_out_single, b_out_double;
    logic [10:0] b_out_data;
    logic [15:0] b_out_code;
    logic [3:0]  b_out_syn;
    logic [7:0]  b_corr, b_uncorr;

    hamming_secded_pipe #(.DATA_W(4), .CNT_W(2)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_vld), .in_ready(a_in_ready), .in_mode(a_mode),
        .in_data(a_data), .in_code(a_code), .out_valid(a_out_valid), .out_ready(a_ordy),
        .out_mode(a_out_mode), .out_data(a_out_data), .out_code(a_out_code),
        .out_syndrome(a_out_syn), .out_single(a_out_single), .out_double(a_out_double),
        .clr_counts(a_clr), .corr_count(a_corr), .uncorr_count(a_uncorr)
    );

    hamming_secded_pipe #(.DATA_W(11), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_vld), .in_ready(b_in_ready), .in_mode(b_mode),
        .in_data(b_data), .in_code(b_code), .out_valid(b_out_valid), .out_ready(b_ordy),
        .out_mode(b_out_mode), .out_data(b_out_data), .out_code(b_out_code),
        .out_syndrome(b_out_syn), .out_single(b_out_single), .out_double(b_out_double),
        .clr_counts(b_clr), .corr_count(b_corr), .uncorr_count(b_uncorr)
    );

    logic [63:0] cap_valid, cap_mode, cap_data, cap_code, cap_syn, cap_sg, cap_db, cap_cor, cap_unc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic tb_pow2(input int x);
        return (x > 0) && ((x & (x - 1)) == 0);
    endfunction

    function automatic logic [63:0] m_enc(input int dw, input logic [63:0] d);
        int pw, cw, pos;
        logic [63:0] c;
        logic b;
        pw = 1;
        while ((1 << pw) < dw + pw + 1) pw++;
        cw = dw + pw + 1;
        c = '0;
        pos = 3;
        for (int i = 0; i < dw; i++) begin
            while (tb_pow2(pos)) pos++;
            c[pos] = d[i];
            pos++;
        end
        for (int k = 0; k < pw; k++) begin
            b = 1'b0;
            for (int p = 3; p < cw; p++) if (!tb_pow2(p) && p[k]) b ^= c[p];
            c[1 << k] = b;
        end
        c[0] = ^c;
        return c;
    endfunction

    function automatic logic [63:0] m_ext(input int dw, input logic [63:0] c);
        logic [63:0] d;
        int pos;
        d = '0;
        pos = 3;
        for (int i = 0; i < dw; i++) begin
            while (tb_pow2(pos)) pos++;
            d[i] = c[pos];
            pos++;
        end
        return d;
    endfunction

    task automatic a_run(input logic m, input logic [3:0] d, input logic [7:0] c, input logic clr_x);
        int n;
        a_vld = 1'b1; a_mode = m; a_data = d; a_code = c; a_ordy = 1'b1;
        #1;
        n = 0;
        while (!a_in_ready && n < 20) begin @(posedge clk); #1; n++; end
        if (n >= 20) chk("a_accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        a_vld = 1'b0;
        @(posedge clk); #1;
        cap_valid = 64'(a_out_valid); cap_mode = 64'(a_out_mode); cap_data = 64'(a_out_data);
        cap_code = 64'(a_out_code); cap_syn = 64'(a_out_syn);
        cap_sg = 64'(a_out_single); cap_db = 64'(a_out_double);
        a_clr = clr_x;
        @(posedge clk); #1;
        a_clr = 1'b0;
        cap_cor = 64'(a_corr); cap_unc = 64'(a_uncorr);
    endtask

    task automatic b_run(input logic m, input logic [10:0] d, input logic [15:0] c);
        int n;
        b_vld = 1'b1; b_mode = m; b_data = d; b_code = c; b_ordy = 1'b1;
        #1;
        n = 0;
        while (!b_in_ready && n < 20) begin @(posedge clk); #1; n++; end
        if (n >= 20) chk("b_accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        b_vld = 1'b0;
        @(posedge clk); #1;
        cap_valid = 64'(b_out_valid); cap_mode = 64'(b_out_mode); cap_data = 64'(b_out_data);
        cap_code = 64'(b_out_code); cap_syn = 64'(b_out_syn);
        cap_sg = 64'(b_out_single); cap_db = 64'(b_out_double);
        @(posedge clk); #1;
        cap_cor = 64'(b_corr); cap_unc = 64'(b_uncorr);
    endtask

    typedef struct {
        logic       m;
        logic [3:0] d;
        logic [7:0] c;
        logic [3:0] ed;
        logic [7:0] ec;
        logic [2:0] es;
        logic       esg;
        logic       edb;
        logic [1:0] ecor;
        logic [1:0] eunc;
    } vec_t;

    vec_t tbl[11];

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, got, nerr, p1, p2, ecor, eunc;
        logic acc, xf, held, saw_nr;
        logic [7:0] hcode;
        logic [63:0] cw, rx, d;

        //        m  d     c       ed    ec     es    sg    db    cor   unc
        tbl[0]  = '{1'b0, 4'hA, 8'h00, 4'hA, 8'hA5, 3'd0, 1'b0, 1'b0, 2'd0, 2'd0};
        tbl[1]  = '{1'b1, 4'h0, 8'hA5, 4'hA, 8'hA5, 3'd0, 1'b0, 1'b0, 2'd0, 2'd0};
        tbl[2]  = '{1'b1, 4'h0, 8'h85, 4'hA, 8'hA5, 3'd5, 1'b1, 1'b0, 2'd1, 2'd0};
        tbl[3]  = '{1'b1, 4'h0, 8'hA4, 4'hA, 8'hA5, 3'd0, 1'b1, 1'b0, 2'd2, 2'd0};
        tbl[4]  = '{1'b1, 4'h0, 8'hC5, 4'hC, 8'hC5, 3'd3, 1'b0, 1'b1, 2'd2, 2'd1};
        tbl[5]  = '{1'b0, 4'h0, 8'h00, 4'h0, 8'h00, 3'd0, 1'b0, 1'b0, 2'd2, 2'd1};
        tbl[6]  = '{1'b0, 4'hF, 8'h00, 4'hF, 8'hFF, 3'd0, 1'b0, 1'b0, 2'd2, 2'd1};
        tbl[7]  = '{1'b1, 4'h0, 8'h01, 4'h0, 8'h00, 3'd0, 1'b1, 1'b0, 2'd3, 2'd1};
        tbl[8]  = '{1'b1, 4'h0, 8'h03, 4'h0, 8'h03, 3'd1, 1'b0, 1'b1, 2'd3, 2'd2};
        tbl[9]  = '{1'b0, 4'h1, 8'h00, 4'h1, 8'h0F, 3'd0, 1'b0, 1'b0, 2'd3, 2'd2};
        tbl[10] = '{1'b1, 4'h0, 8'h8F, 4'h1, 8'h0F, 3'd7, 1'b1, 1'b0, 2'd3, 2'd2};

        rst = 1'b1;
        a_vld = 0; a_mode = 0; a_data = 0; a_code = 0; a_ordy = 1; a_clr = 0;
        b_vld = 0; b_mode = 0; b_data = 0; b_code = 0; b_ordy = 1; b_clr = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_out_code", 64'(a_out_code), 64'd0);
        chk("rst_corr", 64'(a_corr), 64'd0);
        chk("rst_in_ready", 64'(a_in_ready), 64'd1);

        for (int i = 0; i < 11; i++) begin
            a_run(tbl[i].m, tbl[i].d, tbl[i].c, 1'b0);
            chk($sformatf("v%0d_valid", i), cap_valid, 64'd1);
            chk($sformatf("v%0d_mode", i), cap_mode, 64'(tbl[i].m));
            chk($sformatf("v%0d_data", i), cap_data, 64'(tbl[i].ed));
            chk($sformatf("v%0d_code", i), cap_code, 64'(tbl[i].ec));
            chk($sformatf("v%0d_syn", i), cap_syn, 64'(tbl[i].es));
            chk($sformatf("v%0d_single", i), cap_sg, 64'(tbl[i].esg));
            chk($sformatf("v%0d_double", i), cap_db, 64'(tbl[i].edb));
            chk($sformatf("v%0d_corr", i), cap_cor, 64'(tbl[i].ecor));
            chk($sformatf("v%0d_uncorr", i), cap_unc, 64'(tbl[i].eunc));
        end

        // Backpressure: 6 encodes, out_ready low in cycles 3..6
        sent = 0; got = 0; held = 0; saw_nr = 0; hcode = '0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            a_vld = (sent < 6); a_mode = 1'b0; a_data = 4'(sent + 1);
            a_ordy = !(c >= 3 && c <= 6);
            #1;
            acc = a_vld && a_in_ready;
            xf  = a_out_valid && a_ordy;
            if (!a_in_ready) saw_nr = 1'b1;
            if (a_out_valid && !a_ordy) begin
                if (held) chk("bp_stable", 64'(a_out_code), 64'(hcode));
                hcode = a_out_code;
                held  = 1'b1;
            end
            if (xf) begin
                chk("bp_data", 64'(a_out_data), 64'(got + 1));
                chk("bp_code", 64'(a_out_code), m_enc(4, 64'(got + 1)));
                got++;
                held = 1'b0;
            end
            @(posedge clk); #1;
            if (acc) sent++;
        end
        a_vld = 1'b0; a_ordy = 1'b1;
        chk("bp_count", 64'(got), 64'd6);
        chk("bp_in_ready_drop", 64'(saw_nr), 64'd1);

        // Saturation and clear priority
        a_clr = 1'b1; @(posedge clk); #1; a_clr = 1'b0;
        chk("clr_corr", 64'(a_corr), 64'd0);
        chk("clr_uncorr", 64'(a_uncorr), 64'd0);
        for (int k = 1; k <= 5; k++) begin
            a_run(1'b1, 4'h0, 8'h85, 1'b0);
            chk($sformatf("sat_corr%0d", k), cap_cor, 64'((k > 3) ? 3 : k));
        end
        a_run(1'b1, 4'h0, 8'h85, 1'b1);
        chk("clr_wins_single", cap_sg, 64'd1);
        chk("clr_wins_corr", cap_cor, 64'd0);

        // DATA_W=11 random encode / inject / decode
        ecor = 0; eunc = 0;
        for (int it = 0; it < 30; it++) begin
            d  = 64'($urandom_range(0, 2047));
            cw = m_enc(11, d);
            b_run(1'b0, d[10:0], 16'h0);
            chk("r_enc_code", cap_code, cw);
            chk("r_enc_flags", {cap_syn[3:0], cap_sg[0], cap_db[0]}, 64'd0);
            nerr = $urandom_range(0, 2);
            p1 = $urandom_range(0, 15);
            p2 = (p1 + $urandom_range(1, 15)) % 16;
            rx = cw;
            if (nerr >= 1) rx[p1] = ~rx[p1];
            if (nerr == 2) rx[p2] = ~rx[p2];
            if (nerr == 1) ecor++;
            if (nerr == 2) eunc++;
            b_run(1'b1, 11'h0, rx[15:0]);
            chk("r_dec_single", cap_sg, 64'(nerr == 1));
            chk("r_dec_double", cap_db, 64'(nerr == 2));
            chk("r_dec_syn", cap_syn, (nerr == 0) ? 64'd0 : (nerr == 1) ? 64'(p1) : 64'(p1 ^ p2));
            chk("r_dec_code", cap_code, (nerr == 2) ? rx : cw);
            chk("r_dec_data", cap_data, (nerr == 2) ? m_ext(11, rx) : d);
            chk("r_corr", cap_cor, 64'(ecor));
            chk("r_uncorr", cap_unc, 64'(eunc));
        end

        // Mid-stream reset with both stages full
        b_vld = 1'b1; b_mode = 1'b0; b_data = 11'h5A5; b_ordy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_full", 64'(b_out_valid), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; b_vld = 1'b0; b_ordy = 1'b1;
        chk("mrst_valid", 64'(b_out_valid), 64'd0);
        chk("mrst_code", 64'(b_out_code), 64'd0);
        chk("mrst_data", 64'(b_out_data), 64'd0);
        chk("mrst_corr", 64'(b_corr), 64'd0);
        chk("mrst_uncorr", 64'(b_uncorr), 64'd0);
        chk("mrst_in_ready", 64'(b_in_ready), 64'd1);
        @(posedge clk); #1;
        chk("mrst_discard1", 64'(b_out_valid), 64'd0);
        @(posedge clk); #1;
        chk("mrst_discard2", 64'(b_out_valid), 64'd0);
        b_run(1'b0, 11'h3C7, 16'h0);
        chk("post_rst_code", cap_code, m_enc(11, 64'h3C7));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
